// File: rtl/rr_arb_2to1.sv
// Two-requester round-robin arbiter feeding one registered output slot.
// Optional per-requester transfer counters: define RR_ARB_2TO1_CNT_EN.
module rr_arb_2to1 #(
   parameter int BIT_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 a_valid_i,
   input  logic [BIT_WIDTH-1:0] a_data_i,
   output logic                 a_ready_o,
   input  logic                 b_valid_i,
   input  logic [BIT_WIDTH-1:0] b_data_i,
   output logic                 b_ready_o,
   output logic                 y_valid_o,
   output logic [BIT_WIDTH-1:0] y_data_o,
   input  logic                 y_ready_i,
   output logic                 y_src_o
`ifdef RR_ARB_2TO1_CNT_EN
   ,
   output logic [15:0]          cnt_a_o,
   output logic [15:0]          cnt_b_o
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic                 last_grant_q;
   logic [BIT_WIDTH-1:0] data_q;
   logic                 src_q;
   logic                 free;
   logic                 grant_a;
   logic                 grant_b;
   logic                 in_xfer;
   logic                 out_xfer;

   // last_grant_q = 1 means B was served last, so A wins the next tie
   always_comb begin
      free    = (state_q == EMPTY) || y_ready_i;
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (free && !rst_i) begin
         grant_a = a_valid_i && (!b_valid_i || last_grant_q);
         grant_b = b_valid_i && (!a_valid_i || !last_grant_q);
      end
   end

   assign a_ready_o = grant_a;
   assign b_ready_o = grant_b;
   assign in_xfer   = grant_a || grant_b;
   assign out_xfer  = (state_q == FULL) && y_ready_i;

   always_comb begin
      state_d = state_q;
      if (in_xfer) begin
         state_d = FULL;
      end else if (out_xfer) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q       <= '0;
         src_q        <= 1'b0;
         last_grant_q <= 1'b1;
      end else if (in_xfer) begin
         data_q       <= grant_b ? b_data_i : a_data_i;
         src_q        <= grant_b;
         last_grant_q <= grant_b;
      end
   end

   assign y_valid_o = (state_q == FULL);
   assign y_data_o  = data_q;
   assign y_src_o   = src_q;

`ifdef RR_ARB_2TO1_CNT_EN
   logic [15:0] cnt_a_q;
   logic [15:0] cnt_b_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         if (grant_a && cnt_a_q != 16'hFFFF) begin
            cnt_a_q <= cnt_a_q + 16'd1;
         end
         if (grant_b && cnt_b_q != 16'hFFFF) begin
            cnt_b_q <= cnt_b_q + 16'd1;
         end
      end
   end

   assign cnt_a_o = cnt_a_q;
   assign cnt_b_o = cnt_b_q;
`endif

endmodule
